// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB host: FSM state encoding and the I2C controller register map.
package apb_i2c_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RDLAT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS,
    RDLAT  = ST_RDLAT
  } apb_state_t;

  // The slave decodes only addr[7:5]; these are the register base addresses.
  localparam logic [7:0] PRESCALE_ADDR = 8'h20;
  localparam logic [7:0] SLV_ADDR_ADDR = 8'h40;
  localparam logic [7:0] STATUS_ADDR   = 8'h60;
  localparam logic [7:0] TX_ADDR       = 8'h80;
  localparam logic [7:0] RX_ADDR       = 8'hA0;
  localparam logic [7:0] CMD_ADDR      = 8'hC0;

  function automatic logic [2:0] reg_index(input logic [7:0] addr);
    return addr[7:5];
  endfunction

endpackage

// File: rtl/apb_i2c_host_master.sv
// APB initiator turning single valid/ready requests into SETUP/ACCESS transfers with a response pulse.
// Optional ACCESS-phase abort is compiled in with `define APB_HOST_TIMEOUT_EN.
module apb_i2c_host_master
  import apb_i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit LATE_RDATA     = 1'b1
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSELx,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic       PREADY,
  input  logic [7:0] PRDATA
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 31)) begin : g_bad_timeout_cfg
    $error("TIMEOUT_CYCLES must fit the 5-bit wait counter (1..31)");
  end

  apb_state_t state, state_nxt;
  logic       psel_nxt, penable_nxt, pwrite_nxt;
  logic [7:0] paddr_nxt, pwdata_nxt, rdata_nxt;
  logic       rsp_valid_nxt, rsp_err_nxt;
  logic       timeout_hit;

`ifdef APB_HOST_TIMEOUT_EN
  logic [4:0] wait_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= 5'd0;
    end else if (state == IDLE && req_valid) begin
      wait_cnt <= 5'd0;
    end else if (state == ACCESS && !PREADY) begin
      wait_cnt <= wait_cnt + 5'd1;
    end
  end

  // Fires on the wait cycle that brings the count up to TIMEOUT_CYCLES.
  assign timeout_hit = (state == ACCESS) && !PREADY &&
                       ((wait_cnt + 5'd1) == 5'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  assign req_ready = (state == IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= 8'h00;
      PWDATA    <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      PSELx     <= psel_nxt;
      PENABLE   <= penable_nxt;
      PWRITE    <= pwrite_nxt;
      PADDR     <= paddr_nxt;
      PWDATA    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rdata_nxt;
      rsp_err   <= rsp_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    psel_nxt      = PSELx;
    penable_nxt   = PENABLE;
    pwrite_nxt    = PWRITE;
    paddr_nxt     = PADDR;
    pwdata_nxt    = PWDATA;
    rsp_valid_nxt = 1'b0;
    rdata_nxt     = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt   = SETUP;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          paddr_nxt   = req_addr;
          pwrite_nxt  = req_write;
          if (req_write) pwdata_nxt = req_wdata;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (timeout_hit) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rdata_nxt     = 8'h00;
          state_nxt     = IDLE;
        end else if (PREADY) begin
          // Dropping PSELx here guarantees an idle bus cycle before the next SETUP.
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          if (PWRITE) begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b0;
            rdata_nxt     = 8'h00;
            state_nxt     = IDLE;
          end else if (!LATE_RDATA) begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b0;
            rdata_nxt     = PRDATA;
            state_nxt     = IDLE;
          end else begin
            state_nxt = RDLAT;
          end
        end
      end
      RDLAT: begin
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = 1'b0;
        rdata_nxt     = PRDATA;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_i2c_host_master.sv
// Bench: two hosts in lockstep, one with late-PRDATA against a registered slave, one standard against an ideal slave.
module tb_apb_i2c_host_master;
  import apb_i2c_pkg::*;

  localparam int TMO = 16;

  logic            PCLK;
  logic            PRESETn;
  logic            req_valid, req_write;
  logic [7:0]      req_addr, req_wdata;
  logic [1:0]      req_ready, rsp_valid, rsp_err, psel, penable, pwrite, pready;
  logic [1:0][7:0] rsp_rdata, paddr, pwdata, prdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall    = 0;

  logic [40:0] exp_q0[$];
  logic [40:0] exp_q1[$];
  logic [7:0]  model_regs [8];
  logic [7:0]  last_wdata, last_addr;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] regs [8];
    logic [7:0] prdata_q;
    int         wcnt;

    apb_i2c_host_master #(.TIMEOUT_CYCLES(TMO), .LATE_RDATA(g == 0 ? 1'b1 : 1'b0)) u_dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_ready(req_ready[g]), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
      .PSELx(psel[g]), .PENABLE(penable[g]), .PWRITE(pwrite[g]),
      .PADDR(paddr[g]), .PWDATA(pwdata[g]),
      .PREADY(pready[g]), .PRDATA(prdata[g])
    );

    assign pready[g] = (wcnt >= stall);
    assign prdata[g] = (g == 0) ? prdata_q : regs[paddr[g][7:5]];

    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        wcnt     <= 0;
        prdata_q <= 8'h00;
      end else begin
        if (psel[g] && penable[g] && !pready[g]) wcnt <= wcnt + 1;
        else if (!(psel[g] && penable[g]))       wcnt <= 0;
        if (psel[g] && penable[g] && pready[g] && !pwrite[g]) prdata_q <= regs[paddr[g][7:5]];
      end
    end

    always_ff @(posedge PCLK) begin
      if (psel[g] && penable[g] && pready[g] && pwrite[g]) regs[paddr[g][7:5]] <= pwdata[g];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rsp(input int g);
    logic [40:0] e;
    if (rsp_valid[g]) begin
      if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected dut%0d: got rsp_valid=1, required no response (t=%0t)", g, $time);
      end else begin
        if (g == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        check($sformatf("rsp_cycle dut%0d", g), cyc, e[40:9]);
        check($sformatf("rsp_rdata dut%0d", g), {24'd0, rsp_rdata[g]}, {24'd0, e[7:0]});
        check($sformatf("rsp_err dut%0d", g), {31'd0, rsp_err[g]}, {31'd0, e[8]});
      end
    end
  endtask

  // One clock: advance past the active edge, then sample on the falling edge.
  task automatic tick();
    @(posedge PCLK);
    cyc++;
    @(negedge PCLK);
    check_rsp(0);
    check_rsp(1);
  endtask

  task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d, input int waits);
    int         b;
    int         due;
    logic       to;
    logic [7:0] er;
    logic [7:0] exp_pw;
    stall = waits;
`ifdef APB_HOST_TIMEOUT_EN
    to = (waits >= TMO);
`else
    to = 1'b0;
`endif
    b = 0;
    while (req_ready != 2'b11 && b < 40) begin
      tick();
      b++;
    end
    check("req_ready_idle", {30'd0, req_ready}, 32'd3);
    check("idle_gap_psel", {30'd0, psel}, 32'd0);
    for (int g = 0; g < 2; g++) begin
      check("idle_paddr_hold", {24'd0, paddr[g]}, {24'd0, last_addr});
      check("idle_pwdata_hold", {24'd0, pwdata[g]}, {24'd0, last_wdata});
    end
    if (to) begin
      exp_q0.push_back({32'(cyc + 2 + TMO), 1'b1, 8'h00});
      exp_q1.push_back({32'(cyc + 2 + TMO), 1'b1, 8'h00});
    end else begin
      er  = w ? 8'h00 : model_regs[reg_index(a)];
      due = cyc + 3 + waits;
      exp_q1.push_back({32'(due), 1'b0, er});
      exp_q0.push_back({32'(due + (w ? 0 : 1)), 1'b0, er});
      if (w) model_regs[reg_index(a)] = d;
    end
    exp_pw    = w ? d : last_wdata;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_write = 1'(~w);
    req_addr  = 8'($urandom_range(0, 255));
    req_wdata = 8'($urandom_range(0, 255));
    check("setup_psel", {30'd0, psel}, 32'd3);
    check("setup_penable", {30'd0, penable}, 32'd0);
    b = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && b < 80) begin
      tick();
      b++;
      for (int g = 0; g < 2; g++) begin
        if (psel[g]) begin
          check("access_penable", {31'd0, penable[g]}, 32'd1);
          check("access_paddr", {24'd0, paddr[g]}, {24'd0, a});
          check("access_pwrite", {31'd0, pwrite[g]}, {31'd0, w});
          check("access_pwdata", {24'd0, pwdata[g]}, {24'd0, exp_pw});
        end
      end
    end
    check("rsp_arrived", exp_q0.size() + exp_q1.size(), 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    last_addr = a;
    if (w) last_wdata = d;
  endtask

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         waits;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [7:0] ra, rd;

    vt[0] = '{1'b1, PRESCALE_ADDR, 8'h4A, 0};
    vt[1] = '{1'b1, STATUS_ADDR,   8'h50, 0};
    vt[2] = '{1'b0, STATUS_ADDR,   8'h00, 0};
    vt[3] = '{1'b1, TX_ADDR,       8'hA5, 0};
    vt[4] = '{1'b1, CMD_ADDR,      8'h90, 0};
    vt[5] = '{1'b0, TX_ADDR + 8'h07, 8'h00, 0};
    vt[6] = '{1'b0, PRESCALE_ADDR, 8'h00, 5};
    vt[7] = '{1'b1, RX_ADDR,       8'h33, 2};
    vt[8] = '{1'b0, RX_ADDR,       8'h00, TMO - 1};
    vt[9] = '{1'b1, SLV_ADDR_ADDR + 8'h1F, 8'($urandom_range(0, 255)), 1};

    for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
    last_wdata = 8'h00;
    last_addr  = 8'h00;
    PRESETn    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 8'h00;
    req_wdata  = 8'h00;
    repeat (3) @(negedge PCLK);
    for (int g = 0; g < 2; g++) begin
      check("reset_psel", {31'd0, psel[g]}, 32'd0);
      check("reset_penable", {31'd0, penable[g]}, 32'd0);
      check("reset_pwrite", {31'd0, pwrite[g]}, 32'd0);
      check("reset_paddr", {24'd0, paddr[g]}, 32'd0);
      check("reset_pwdata", {24'd0, pwdata[g]}, 32'd0);
      check("reset_rsp_valid", {31'd0, rsp_valid[g]}, 32'd0);
      check("reset_rsp_rdata", {24'd0, rsp_rdata[g]}, 32'd0);
      check("reset_rsp_err", {31'd0, rsp_err[g]}, 32'd0);
      check("reset_req_ready", {31'd0, req_ready[g]}, 32'd1);
    end
    PRESETn = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) do_req(vt[i].w, vt[i].a, vt[i].d, vt[i].waits);
    do_req(1'b0, SLV_ADDR_ADDR, 8'h00, 0);

    for (int i = 0; i < 3; i++) begin
      ra = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      rd = 8'($urandom_range(0, 255));
      do_req(1'b1, ra, rd, $urandom_range(0, 3));
      do_req(1'b0, ra, 8'h00, $urandom_range(0, 3));
    end

    // A long stall: aborts when the timeout is built in, otherwise simply completes late.
    do_req(1'b0, CMD_ADDR, 8'h00, TMO + 9);
    check("post_stall_req_ready", {30'd0, req_ready}, 32'd3);
    do_req(1'b0, CMD_ADDR, 8'h00, 0);

    // Reset in the middle of an ACCESS wait: everything clears at once, no response.
    stall     = 1000;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = RX_ADDR;
    req_wdata = 8'h77;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("pre_reset_access", {30'd0, psel & penable}, 32'd3);
    #2 PRESETn = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check("midreset_psel", {31'd0, psel[g]}, 32'd0);
      check("midreset_penable", {31'd0, penable[g]}, 32'd0);
      check("midreset_paddr", {24'd0, paddr[g]}, 32'd0);
      check("midreset_pwdata", {24'd0, pwdata[g]}, 32'd0);
      check("midreset_pwrite", {31'd0, pwrite[g]}, 32'd0);
      check("midreset_rsp_valid", {31'd0, rsp_valid[g]}, 32'd0);
      check("midreset_rsp_rdata", {24'd0, rsp_rdata[g]}, 32'd0);
      check("midreset_req_ready", {31'd0, req_ready[g]}, 32'd1);
    end
    tick();
    tick();
    PRESETn    = 1'b1;
    last_wdata = 8'h00;
    last_addr  = 8'h00;
    tick();
    do_req(1'b0, RX_ADDR, 8'h00, 0);
    do_req(1'b1, TX_ADDR, 8'h3C, 1);
    do_req(1'b0, TX_ADDR, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
